// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one RISC-V branch/SLT comparator between two requesters.
// Operands are registered on accept, the condition is registered in COMPARE, and the result is held until consumed.

module flagger #(
    parameter int unsigned WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    output logic                flag_equal,
    output logic                flag_not_equal,
    output logic                flag_less,
    output logic                flag_u_less
);
    assign flag_equal     = (a == b);
    assign flag_not_equal = (a != b);
    assign flag_less      = ($signed(a) < $signed(b));
    assign flag_u_less    = (a < b);
endmodule

module cmp_arbiter #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned CNTW     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [WORDSIZE-1:0] req0_a,
    input  logic [WORDSIZE-1:0] req0_b,
    input  logic [WORDSIZE-1:0] req1_a,
    input  logic [WORDSIZE-1:0] req1_b,
    input  logic [2:0]          req0_op,
    input  logic [2:0]          req1_op,
    output logic                rsp0_valid,
    output logic                rsp1_valid,
    input  logic                rsp0_ready,
    input  logic                rsp1_ready,
    output logic                rsp_result,
    output logic                rsp_err,
    output logic [CNTW-1:0]     grant_count0,
    output logic [CNTW-1:0]     grant_count1
);
    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_RESPOND} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic                result_q, result_d;
    logic                err_q, err_d;
    logic [CNTW-1:0]     cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic any_valid_c, grant_c;
    logic f_eq, f_ne, f_lt, f_ult;

    flagger #(.WORDSIZE(WORDSIZE)) u_flagger (
        .a              (a_q),
        .b              (b_q),
        .flag_equal     (f_eq),
        .flag_not_equal (f_ne),
        .flag_less      (f_lt),
        .flag_u_less    (f_ult)
    );

    // On a tie, serve the requester that did not win last time.
    always_comb begin
        any_valid_c = req0_valid | req1_valid;
        if (req0_valid && req1_valid) grant_c = ~last_q;
        else                          grant_c = req1_valid;
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        req0_ready = (state_q == S_IDLE) && any_valid_c && !grant_c;
        req1_ready = (state_q == S_IDLE) && any_valid_c &&  grant_c;
        rsp0_valid = (state_q == S_RESPOND) && !owner_q;
        rsp1_valid = (state_q == S_RESPOND) &&  owner_q;

        case (state_q)
            S_IDLE: begin
                if (any_valid_c) begin
                    owner_d = grant_c;
                    last_d  = grant_c;
                    a_d     = grant_c ? req1_a  : req0_a;
                    b_d     = grant_c ? req1_b  : req0_b;
                    op_d    = grant_c ? req1_op : req0_op;
                    if (!grant_c && (cnt0_q != '1)) cnt0_d = cnt0_q + CNTW'(1);
                    if ( grant_c && (cnt1_q != '1)) cnt1_d = cnt1_q + CNTW'(1);
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                err_d = 1'b0;
                case (op_q)
                    OP_EQ:   result_d = f_eq;
                    OP_NE:   result_d = f_ne;
                    OP_LT:   result_d = f_lt;
                    OP_GE:   result_d = ~f_lt;
                    OP_LTU:  result_d = f_ult;
                    OP_GEU:  result_d = ~f_ult;
                    default: begin
                        result_d = 1'b0;
                        err_d    = 1'b1;
                    end
                endcase
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                // Only the owner's ready can retire the response.
                if (owner_q ? rsp1_ready : rsp0_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign rsp_result   = result_q;
    assign rsp_err      = err_q;
    assign grant_count0 = cnt0_q;
    assign grant_count1 = cnt1_q;
endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: stimulus queues expected responses, a monitor checks each response handshake.
module tb_cmp_arbiter;
    localparam int unsigned W  = 64;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic          rsp_result, rsp_err;
    logic [CW-1:0] grant_count0, grant_count1;

    cmp_arbiter #(.WORDSIZE(W), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .grant_count0(grant_count0), .grant_count1(grant_count1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic id;
        logic res;
        logic err;
    } exp_t;

    exp_t        sb[$];
    int unsigned grant_id[$];
    int unsigned grant_cyc[$];
    int unsigned cyc = 0;
    int unsigned acc_cyc[2];
    int unsigned hs_cyc = 0;
    int unsigned passed = 0;
    int unsigned total = 0;
    bit          bp_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic pop_check(input logic id);
        exp_t e;
        hs_cyc = cyc + 1;
        if (sb.size() == 0) begin
            fail("unexpected_response");
        end else begin
            e = sb.pop_front();
            chk("rsp_owner",  64'(id),         64'(e.id));
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_err",    64'(rsp_err),    64'(e.err));
            if (!bp_mode) chk("accept_to_rsp_latency", 64'(hs_cyc - acc_cyc[id]), 64'd2);
        end
    endtask

    // Monitor: logs accepts and checks every response handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                acc_cyc[0] = cyc + 1;
                grant_id.push_back(0);
                grant_cyc.push_back(cyc + 1);
            end
            if (req1_valid && req1_ready) begin
                acc_cyc[1] = cyc + 1;
                grant_id.push_back(1);
                grant_cyc.push_back(cyc + 1);
            end
            if (rsp0_valid && rsp1_valid) fail("both_rsp_valid");
            if (rsp0_valid && rsp0_ready) pop_check(1'b0);
            if (rsp1_valid && rsp1_ready) pop_check(1'b1);
        end
    end

    task automatic push_exp(input logic id, input logic res, input logic err);
        exp_t e;
        e.id = id; e.res = res; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req0_ready"}, 64'(req0_ready), 64'd0);
        chk({tag, "_req1_ready"}, 64'(req1_ready), 64'd0);
        chk({tag, "_rsp0_valid"}, 64'(rsp0_valid), 64'd0);
        chk({tag, "_rsp1_valid"}, 64'(rsp1_valid), 64'd0);
        chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
        chk({tag, "_rsp_err"},    64'(rsp_err),    64'd0);
        chk({tag, "_count0"},     64'(grant_count0), 64'd0);
        chk({tag, "_count1"},     64'(grant_count1), 64'd0);
    endtask

    task automatic wait_accept(input logic id);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("accept_timeout");
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) fail("drain_timeout");
    endtask

    task automatic do_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic er, input logic ee);
        @(posedge clk); #1;
        push_exp(id, er, ee);
        if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        wait_accept(id);
        wait_drain();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sb.delete();
        grant_id.delete();
        grant_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [W-1:0] m1;
        m1 = '1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("por");
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset in the middle of COMPARE drops the transaction.
        req0_a = m1; req0_b = 64'd5; req0_op = 3'b100; req0_valid = 1'b1;
        wait_accept(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        sb.delete(); grant_id.delete(); grant_cyc.delete();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) n++;
        end
        chk("no_rsp_after_reset", 64'(n), 64'd0);

        // Tie: both valid continuously, req0 must win first.
        @(posedge clk); #1;
        req0_a = 64'd3; req0_b = 64'd3; req0_op = 3'b000;
        req1_a = 64'd2; req1_b = 64'd7; req1_op = 3'b101;
        push_exp(1'b0, 1'b1, 1'b0); push_exp(1'b1, 1'b0, 1'b0);
        push_exp(1'b0, 1'b1, 1'b0); push_exp(1'b1, 1'b0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("tie_first_req0_ready", 64'(req0_ready), 64'd1);
        chk("tie_first_req1_ready", 64'(req1_ready), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (grant_id.size() >= 4) break;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();
        if (grant_id.size() != 4) fail("tie_grant_count");
        else begin
            for (int i = 0; i < 4; i++) chk("tie_grant_order", 64'(grant_id[i]), 64'(i % 2));
            for (int i = 1; i < 4; i++) chk("tie_accept_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd3);
        end
        chk("tie_count0", 64'(grant_count0), 64'd2);
        chk("tie_count1", 64'(grant_count1), 64'd2);

        // Signed vs unsigned with a = -1, b = 5.
        do_req(1'b0, m1, 64'd5, 3'b100, 1'b1, 1'b0);
        do_req(1'b0, m1, 64'd5, 3'b110, 1'b0, 1'b0);
        do_req(1'b0, m1, 64'd5, 3'b111, 1'b1, 1'b0);
        do_req(1'b0, m1, 64'd5, 3'b101, 1'b0, 1'b0);

        // Equality, inequality and illegal op codes.
        do_req(1'b1, 64'd5, 64'd5, 3'b000, 1'b1, 1'b0);
        do_req(1'b1, 64'd1, 64'd1, 3'b001, 1'b0, 1'b0);
        do_req(1'b0, 64'd7, 64'd7, 3'b010, 1'b0, 1'b1);
        do_req(1'b1, 64'd9, 64'd4, 3'b011, 1'b0, 1'b1);
        do_req(1'b1, 64'd9, 64'd4, 3'b001, 1'b1, 1'b0);

        // Response backpressure on rsp0 while req1 waits.
        @(posedge clk); #1;
        bp_mode = 1'b1;
        rsp0_ready = 1'b0;
        push_exp(1'b0, 1'b1, 1'b0);
        push_exp(1'b1, 1'b1, 1'b0);
        req0_a = 64'd1; req0_b = 64'd2; req0_op = 3'b110; req0_valid = 1'b1;
        wait_accept(1'b0);
        req1_a = 64'd4; req1_b = 64'd4; req1_op = 3'b000; req1_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin n = 1; break; end
        end
        if (n == 0) fail("bp_rsp0_timeout");
        repeat (10) begin
            @(negedge clk);
            chk("bp_rsp0_valid", 64'(rsp0_valid), 64'd1);
            chk("bp_rsp_result", 64'(rsp_result), 64'd1);
            chk("bp_req1_ready", 64'(req1_ready), 64'd0);
            chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd0);
        end
        @(posedge clk); #1 rsp0_ready = 1'b1;
        wait_accept(1'b1);
        chk("bp_accept_after_handshake", 64'(acc_cyc[1]), 64'(hs_cyc + 1));
        bp_mode = 1'b0;
        wait_drain();

        // Counter saturation with a 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) do_req(1'b0, 64'(i), 64'd2, 3'b110, (i < 2) ? 1'b1 : 1'b0, 1'b0);
        chk("sat_count0", 64'(grant_count0), 64'd3);
        chk("sat_count1", 64'(grant_count1), 64'd0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) fail("scoreboard_leftover");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
